// File: rtl/sw_mode_select.sv
// Programming-mode selector: synchronises and debounces N_SW slide switches, then
// drives a registered one-hot mode vector, deferring changes while downstream is busy.
module sw_mode_select #(
  parameter int N_SW       = 3,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw,
  input  logic            busy,
  output logic [N_SW-1:0] prog,
  output logic            mode_chg,
  output logic            conflict,
  output logic            pending
);

  localparam int POP_W = $clog2(N_SW + 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [N_SW-1:0] sync1_q;
  logic [N_SW-1:0] sync2_q;
  logic [N_SW-1:0] deb_q;
  logic [N_SW-1:0] deb_d;
  logic [N_SW-1:0] prog_q;
  logic [N_SW-1:0] prog_d;
  logic            mode_chg_q;
  logic            mode_chg_d;
  logic            conflict_q;
  logic            conflict_d;
  state_t          state_q;
  state_t          state_d;
  logic [POP_W-1:0] ones;
  logic [N_SW-1:0] target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  // A level is accepted only after differing from the debounced value on
  // DEB_CYCLES consecutive edges; any return to the old value restarts the count.
  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d     = cnt_q;
        deb_d[gi] = deb_q[gi];
        if (sync2_q[gi] == deb_q[gi]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
          deb_d[gi] = sync2_q[gi];
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_d;
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < N_SW; i++) begin
      ones = ones + POP_W'(deb_q[i]);
    end
  end

  // No priority encoding: anything other than exactly one switch means "no mode".
  assign target     = (ones == POP_W'(1)) ? deb_q : '0;
  assign conflict_d = (ones >= POP_W'(2));

  always_comb begin
    state_d    = state_q;
    prog_d     = prog_q;
    mode_chg_d = 1'b0;
    if (state_q == ST_STABLE) begin
      if (target != prog_q) begin
        if (busy) begin
          state_d = ST_PENDING;
        end else begin
          prog_d     = target;
          mode_chg_d = 1'b1;
        end
      end
    end else begin
      // Held changes resolve against whatever the target is when busy drops.
      if (!busy) begin
        state_d = ST_STABLE;
        if (target != prog_q) begin
          prog_d     = target;
          mode_chg_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STABLE;
      prog_q     <= '0;
      mode_chg_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_q     <= prog_d;
      mode_chg_q <= mode_chg_d;
      conflict_q <= conflict_d;
    end
  end

  assign prog     = prog_q;
  assign mode_chg = mode_chg_q;
  assign conflict = conflict_q;
  assign pending  = (state_q == ST_PENDING);

endmodule

// File: tb/tb_sw_mode_select.sv
// Bench for sw_mode_select: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a window-based model.
module tb_sw_mode_select;

  localparam int N   = 3;
  localparam int DEB = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] sw;
  logic         busy;
  logic [N-1:0] prog;
  logic         mode_chg;
  logic         conflict;
  logic         pending;

  int checks;
  int errors;
  int pulses;

  sw_mode_select #(.N_SW(N), .DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .busy     (busy),
    .prog     (prog),
    .mode_chg (mode_chg),
    .conflict (conflict),
    .pending  (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: two-edge synchroniser delay, then a bit flips once its last DEB
  // synchronised samples all disagree with the accepted value.
  logic [N-1:0]   m_s1, m_s2, m_deb, m_prog, m_tgt;
  logic [DEB-1:0] m_hist [N];
  logic           m_chg, m_conf, m_pend;
  int             m_pc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_prog = '0;
      m_chg = 1'b0; m_conf = 1'b0; m_pend = 1'b0;
      for (int i = 0; i < N; i++) m_hist[i] = '0;
    end else begin
      m_pc   = $countones(m_deb);
      m_tgt  = (m_pc == 1) ? m_deb : '0;
      m_conf = (m_pc >= 2);
      m_chg  = 1'b0;
      if (busy) begin
        m_pend = m_pend || (m_tgt != m_prog);
      end else begin
        if (m_tgt != m_prog) begin
          m_prog = m_tgt;
          m_chg  = 1'b1;
        end
        m_pend = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
        if (m_hist[i] == {DEB{~m_deb[i]}}) m_deb[i] = m_s2[i];
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  always @(negedge clk) begin
    chk("prog", 32'(prog), 32'(m_prog));
    chk("mode_chg", 32'(mode_chg), 32'(m_chg));
    chk("conflict", 32'(conflict), 32'(m_conf));
    chk("pending", 32'(pending), 32'(m_pend));
    if (mode_chg === 1'b1) pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int p0;
  int hold;

  initial begin
    checks = 0; errors = 0; pulses = 0;
    reset = 1'b1; sw = '0; busy = 1'b0;
    tick(3);

    // Clean switch: deb on edge 6, prog and pulse on edge 7 only.
    reset = 1'b0; sw = 3'b010;
    tick(5);
    chk("s1_deb_e5", 32'(dut.deb_q), 32'h0);
    tick(1);
    chk("s1_deb_e6", 32'(dut.deb_q), 32'h2);
    chk("s1_prog_e6", 32'(prog), 32'h0);
    tick(1);
    chk("s1_prog_e7", 32'(prog), 32'h2);
    chk("s1_chg_e7", 32'(mode_chg), 32'h1);
    chk("s1_conf", 32'(conflict), 32'h0);
    tick(1);
    chk("s1_chg_e8", 32'(mode_chg), 32'h0);
    $display("scenario clean_switch prog=%b", prog);

    // Three-cycle glitch on sw[0] is rejected.
    p0 = pulses;
    sw = 3'b011;
    tick(3);
    sw = 3'b010;
    tick(12);
    chk("s2_prog", 32'(prog), 32'h2);
    chk("s2_deb", 32'(dut.deb_q), 32'h2);
    chk("s2_pulses", 32'(pulses - p0), 32'h0);
    chk("s2_cnt0", 32'(dut.g_deb[0].cnt_q), 32'h0);
    $display("scenario glitch prog=%b", prog);

    // Conflict drops prog to zero, resolving restores a mode.
    sw = 3'b001;
    tick(10);
    chk("s3_prog001", 32'(prog), 32'h1);
    p0 = pulses;
    sw = 3'b101;
    tick(10);
    chk("s3_conf", 32'(conflict), 32'h1);
    chk("s3_prog000", 32'(prog), 32'h0);
    chk("s3_pulse1", 32'(pulses - p0), 32'h1);
    sw = 3'b100;
    tick(10);
    chk("s3_conf0", 32'(conflict), 32'h0);
    chk("s3_prog100", 32'(prog), 32'h4);
    chk("s3_pulse2", 32'(pulses - p0), 32'h2);
    $display("scenario conflict prog=%b", prog);

    // Deferred change applies only the latest target once busy drops.
    sw = 3'b001;
    tick(10);
    p0 = pulses;
    busy = 1'b1; sw = 3'b010;
    tick(10);
    chk("s4_pend", 32'(pending), 32'h1);
    chk("s4_prog_held", 32'(prog), 32'h1);
    sw = 3'b100;
    tick(10);
    chk("s4_prog_held2", 32'(prog), 32'h1);
    busy = 1'b0;
    tick(1);
    chk("s4_prog", 32'(prog), 32'h4);
    chk("s4_chg", 32'(mode_chg), 32'h1);
    chk("s4_pend0", 32'(pending), 32'h0);
    tick(2);
    chk("s4_pulses", 32'(pulses - p0), 32'h1);
    $display("scenario busy_defer prog=%b", prog);

    // Target returns to prog while busy: no pulse.
    sw = 3'b001;
    tick(10);
    p0 = pulses;
    busy = 1'b1; sw = 3'b010;
    tick(10);
    chk("s5_pend", 32'(pending), 32'h1);
    sw = 3'b001;
    tick(10);
    busy = 1'b0;
    tick(2);
    chk("s5_pend0", 32'(pending), 32'h0);
    chk("s5_prog", 32'(prog), 32'h1);
    chk("s5_pulses", 32'(pulses - p0), 32'h0);
    $display("scenario busy_revert prog=%b", prog);

    // Async reset mid-pending and mid-count.
    busy = 1'b1; sw = 3'b010;
    tick(10);
    chk("s6_pend_pre", 32'(pending), 32'h1);
    sw = 3'b100;
    tick(3);
    #2 reset = 1'b1;
    #1;
    chk("s6_prog_rst", 32'(prog), 32'h0);
    chk("s6_pend_rst", 32'(pending), 32'h0);
    chk("s6_chg_rst", 32'(mode_chg), 32'h0);
    chk("s6_conf_rst", 32'(conflict), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0; busy = 1'b0;
    tick(6);
    chk("s6_prog_e6", 32'(prog), 32'h0);
    tick(1);
    chk("s6_prog_e7", 32'(prog), 32'h4);
    chk("s6_chg_e7", 32'(mode_chg), 32'h1);
    $display("scenario async_reset prog=%b", prog);

    // Randomized run; the per-cycle compare process does the checking.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 9) < 6) begin
          sw = '0;
          sw[$urandom_range(0, N - 1)] = 1'b1;
        end else begin
          sw = N'($urandom_range(0, (1 << N) - 1));
        end
        hold = $urandom_range(1, 14);
      end
      hold--;
      if ($urandom_range(0, 7) == 0) busy = ~busy;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 699) == 0) reset = 1'b1;
      tick(1);
    end
    $display("scenario random cycles=4000 pulses=%0d", pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
